// File: rtl/slurm16_memory_arbiter.sv
// Single-port BRAM arbiter for slurm16: data accesses beat instruction fetch.
// Optional fetch starvation guard enabled by defining SLURM16_ARB_STARVE_GUARD_EN.
module slurm16_memory_arbiter #(
  parameter int unsigned ADDR_BITS    = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 instruction_request,
  input  logic [ADDR_BITS-1:0] instruction_address,
  output logic                 instruction_valid,
  output logic [15:0]          instruction_in,
  output logic [ADDR_BITS-1:0] instruction_address_in,
  input  logic                 load_memory,
  input  logic                 store_memory,
  input  logic [ADDR_BITS-1:0] load_store_address,
  input  logic [15:0]          memory_out,
  input  logic [1:0]           memory_mask,
  output logic                 memory_request_successful,
  output logic [15:0]          memory_in,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_wr_data,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_be,
  input  logic [15:0]          mem_rd_data
);

  typedef enum logic {S_RUN, S_FORCE} state_t;

  state_t               state, state_next;
  logic                 data_req, data_grant, fetch_grant;
  logic [ADDR_BITS-1:0] addr_hold;
  logic                 load_pending;

  always_comb begin
    data_req    = load_memory | store_memory;
    data_grant  = 1'b0;
    fetch_grant = 1'b0;
    if (RSTb) begin
      if (state == S_FORCE)         fetch_grant = 1'b1;
      else if (data_req)            data_grant  = 1'b1;
      else if (instruction_request) fetch_grant = 1'b1;
    end
  end

  always_comb begin
    mem_addr  = addr_hold;
    mem_wr_en = 1'b0;
    if (data_grant) begin
      mem_addr  = load_store_address;
      mem_wr_en = store_memory;
    end else if (fetch_grant) begin
      mem_addr  = instruction_address;
    end
  end

  always_comb begin
    mem_be                    = 2'b00;
    mem_wr_data               = '0;
    instruction_in            = '0;
    memory_request_successful = 1'b0;
    if (RSTb) begin
      mem_be                    = (memory_mask == 2'b00) ? 2'b11 : memory_mask;
      mem_wr_data               = memory_out;
      instruction_in            = mem_rd_data;
      memory_request_successful = !data_req | data_grant;
    end
  end

`ifdef SLURM16_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt, cnt_next;

  // Enter S_FORCE as the count reaches the limit so exactly LIMIT data grants precede the forced fetch.
  always_comb begin
    cnt_next   = starve_cnt;
    state_next = S_RUN;
    if (fetch_grant || !instruction_request)
      cnt_next = '0;
    else if (data_grant && starve_cnt != LIMIT)
      cnt_next = starve_cnt + 1'b1;
    if (state == S_RUN && instruction_request && cnt_next == LIMIT)
      state_next = S_FORCE;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) starve_cnt <= '0;
    else       starve_cnt <= cnt_next;
  end
`else
  always_comb state_next = S_RUN;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state                  <= S_RUN;
      instruction_valid      <= 1'b0;
      instruction_address_in <= '0;
      addr_hold              <= '0;
      load_pending           <= 1'b0;
      memory_in              <= '0;
    end else begin
      state             <= state_next;
      instruction_valid <= fetch_grant;
      if (fetch_grant) instruction_address_in <= instruction_address;
      addr_hold    <= mem_addr;
      load_pending <= data_grant & load_memory & ~store_memory;
      if (load_pending) memory_in <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Directed bench for slurm16_memory_arbiter with a byte-enabled synchronous BRAM model.
module tb_slurm16_memory_arbiter;
  localparam int unsigned AB = 15;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic          instruction_request;
  logic [AB-1:0] instruction_address;
  logic          instruction_valid;
  logic [15:0]   instruction_in;
  logic [AB-1:0] instruction_address_in;
  logic          load_memory, store_memory;
  logic [AB-1:0] load_store_address;
  logic [15:0]   memory_out;
  logic [1:0]    memory_mask;
  logic          memory_request_successful;
  logic [15:0]   memory_in;
  logic [AB-1:0] mem_addr;
  logic [15:0]   mem_wr_data;
  logic          mem_wr_en;
  logic [1:0]    mem_be;
  logic [15:0]   mem_rd_data;

  logic [15:0] bram [0:(1<<AB)-1];
  int total = 0;
  int bad   = 0;

  slurm16_memory_arbiter #(.ADDR_BITS(AB), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .instruction_request(instruction_request), .instruction_address(instruction_address),
    .instruction_valid(instruction_valid), .instruction_in(instruction_in),
    .instruction_address_in(instruction_address_in),
    .load_memory(load_memory), .store_memory(store_memory),
    .load_store_address(load_store_address), .memory_out(memory_out),
    .memory_mask(memory_mask), .memory_request_successful(memory_request_successful),
    .memory_in(memory_in), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_be(mem_be), .mem_rd_data(mem_rd_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    mem_rd_data <= bram[mem_addr];
    if (mem_wr_en) begin
      if (mem_be[0]) bram[mem_addr][7:0]  <= mem_wr_data[7:0];
      if (mem_be[1]) bram[mem_addr][15:8] <= mem_wr_data[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ivalid"}, 32'(instruction_valid), 32'h0);
    chk({tag, "_iin"},    32'(instruction_in), 32'h0);
    chk({tag, "_iaddr"},  32'(instruction_address_in), 32'h0);
    chk({tag, "_memin"},  32'(memory_in), 32'h0);
    chk({tag, "_maddr"},  32'(mem_addr), 32'h0);
    chk({tag, "_wren"},   32'(mem_wr_en), 32'h0);
    chk({tag, "_be"},     32'(mem_be), 32'h0);
    chk({tag, "_mrs"},    32'(memory_request_successful), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AB); i++) bram[i] = 16'h0000;
    bram[0] = 16'h3013; bram[1] = 16'h3027; bram[2] = 16'h2112;
    bram[15'h40] = 16'hBEEF; bram[15'h50] = 16'hFFFF;
    mem_rd_data = 16'h0;
    RSTb = 1'b0;
    instruction_request = 1'b0; instruction_address = '0;
    load_memory = 1'b0; store_memory = 1'b0; load_store_address = '0;
    memory_out = 16'h0; memory_mask = 2'b00;
    #2;
    chk_reset_vals("rst");
    tick; tick;
    RSTb = 1'b1;

    // Fetch-only stream
    instruction_request = 1'b1; instruction_address = 15'd0; #1;
    chk("f0_maddr", 32'(mem_addr), 32'd0);
    chk("f0_valid", 32'(instruction_valid), 32'd0);
    tick; instruction_address = 15'd1; #1;
    chk("f1_valid", 32'(instruction_valid), 32'd1);
    chk("f1_data",  32'(instruction_in), 32'h3013);
    chk("f1_addr",  32'(instruction_address_in), 32'd0);
    tick; instruction_address = 15'd2; #1;
    chk("f2_valid", 32'(instruction_valid), 32'd1);
    chk("f2_data",  32'(instruction_in), 32'h3027);
    chk("f2_addr",  32'(instruction_address_in), 32'd1);
    tick; instruction_request = 1'b0; #1;
    chk("f3_valid", 32'(instruction_valid), 32'd1);
    chk("f3_data",  32'(instruction_in), 32'h2112);
    chk("f3_addr",  32'(instruction_address_in), 32'd2);
    chk("idle_hold_maddr", 32'(mem_addr), 32'd2);
    chk("idle_wren", 32'(mem_wr_en), 32'd0);
    tick;
    chk("f4_valid", 32'(instruction_valid), 32'd0);

    // Load/fetch collision
    instruction_request = 1'b1; instruction_address = 15'd5;
    load_memory = 1'b1; load_store_address = 15'h40; #1;
    chk("col_mrs",   32'(memory_request_successful), 32'd1);
    chk("col_maddr", 32'(mem_addr), 32'h40);
    chk("col_wren",  32'(mem_wr_en), 32'd0);
    tick; load_memory = 1'b0; instruction_request = 1'b0; #1;
    chk("col_valid", 32'(instruction_valid), 32'd0);
    tick;
    chk("col_memin", 32'(memory_in), 32'hBEEF);

    // Byte-lane mapping while idle
    memory_mask = 2'b10; #1;
    chk("be_10", 32'(mem_be), 32'h2);
    memory_mask = 2'b11; #1;
    chk("be_11", 32'(mem_be), 32'h3);

    // Low-byte store then load
    store_memory = 1'b1; load_store_address = 15'h50; memory_out = 16'h12AB; memory_mask = 2'b01; #1;
    chk("bs_be",    32'(mem_be), 32'h1);
    chk("bs_wren",  32'(mem_wr_en), 32'd1);
    chk("bs_wdata", 32'(mem_wr_data), 32'h12AB);
    chk("bs_mrs",   32'(memory_request_successful), 32'd1);
    tick; store_memory = 1'b0; load_memory = 1'b1; memory_mask = 2'b00; #1;
    chk("bs_be00", 32'(mem_be), 32'h3);
    chk("bs_ldwren", 32'(mem_wr_en), 32'd0);
    tick; load_memory = 1'b0;
    tick;
    chk("bs_memin", 32'(memory_in), 32'hFFAB);

    // Back-to-back store/load of a full word
    store_memory = 1'b1; load_store_address = 15'h60; memory_out = 16'h5A5A; memory_mask = 2'b00;
    tick; store_memory = 1'b0; load_memory = 1'b1;
    tick; load_memory = 1'b0;
    tick;
    chk("sl_memin", 32'(memory_in), 32'h5A5A);
    instruction_request = 1'b1; instruction_address = 15'd1;
    tick; instruction_request = 1'b0;
    tick;
    chk("memin_hold", 32'(memory_in), 32'h5A5A);

    // Continuous loads against a fetch request
    load_memory = 1'b1; load_store_address = 15'h40;
    instruction_request = 1'b1; instruction_address = 15'd7;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef SLURM16_ARB_STARVE_GUARD_EN
      chk($sformatf("stv_mrs%0d", k), 32'(memory_request_successful), (k % 5 == 4) ? 32'd0 : 32'd1);
      if (k > 0) chk($sformatf("stv_valid%0d", k), 32'(instruction_valid), ((k - 1) % 5 == 4) ? 32'd1 : 32'd0);
`else
      chk($sformatf("stv_mrs%0d", k), 32'(memory_request_successful), 32'd1);
      if (k > 0) chk($sformatf("stv_valid%0d", k), 32'(instruction_valid), 32'd0);
`endif
      tick;
    end
    load_memory = 1'b0; instruction_request = 1'b0;
    tick;

    // Reset pulse with a fetch in flight
    instruction_request = 1'b1; instruction_address = 15'd2;
    tick;
    RSTb = 1'b0; #1;
    chk_reset_vals("rp");
    tick;
    RSTb = 1'b1; #1;
    chk("rp_rel_valid", 32'(instruction_valid), 32'd0);
    tick;
    chk("rp_next_valid", 32'(instruction_valid), 32'd1);
    chk("rp_next_addr",  32'(instruction_address_in), 32'd2);
    instruction_request = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
